// File: rtl/arb4_rr_if.sv
// Request/grant bundle for the 4-way round-robin arbiter.
// The master modport drives requests; the slave modport is the arbiter side.
interface arb4_rr_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       tmo;

  modport master (output req, input gnt, gnt_id, busy, tmo);
  modport slave  (input req, output gnt, gnt_id, busy, tmo);
endinterface

// File: rtl/arb4_rr.sv
// 4-requester round-robin arbiter with registered one-hot grant.
// Optional hold timeout is enabled by defining ARB4_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate any request starting after the last owner
// GRANT | one owner holds gnt until it drops req (or the hold limit expires)
module arb4_rr #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rstn,
  arb4_rr_if.slave   bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       tmo;
  logic [1:0] last;
  logic [1:0] pick;
  logic       pick_vld;

  if (2**CNT_W <= MAX_HOLD) begin : g_cnt_w_chk
    $error("CNT_W too narrow for MAX_HOLD");
  end

`ifdef ARB4_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
`endif

  // First requester after the previous owner, wrapping mod 4.
  always_comb begin
    logic [1:0] idx;
    pick_vld = 1'b0;
    pick     = last;
    idx      = last;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!pick_vld && bus.req[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      gnt    <= 4'b0000;
      gnt_id <= 2'd0;
      busy   <= 1'b0;
      tmo    <= 1'b0;
      last   <= 2'd3;
`ifdef ARB4_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      tmo <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt    <= 4'b0001 << pick;
            gnt_id <= pick;
            last   <= pick;
            busy   <= 1'b1;
            state  <= GRANT;
`ifdef ARB4_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (!bus.req[gnt_id]) begin
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            state <= IDLE;
          end
`ifdef ARB4_TIMEOUT_EN
          else if (hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            tmo   <= 1'b1;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt;
  assign bus.gnt_id = gnt_id;
  assign bus.busy   = busy;
  assign bus.tmo    = tmo;

endmodule
